// File: rtl/motor_move_sequencer.sv
// Relative move sequencer: command handshake, run/brake/done FSM, step counting, stall watchdog
// and signed absolute position. Define MOTOR_SEQ_REVERSE_FAULT_EN to end a move on a reverse step.
module motor_move_sequencer #(
    parameter int STEP_W       = 16,
    parameter int POS_W        = 32,
    parameter int STALL_CYCLES = 100000,
    parameter int BRAKE_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [STEP_W-1:0] i_cmd_steps,
    input  logic              i_cmd_dir,
    input  logic              i_abort,
    input  logic              i_step,
    input  logic              i_polarity,
    output logic              o_motor_en,
    output logic              o_motor_dir,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_status,
    output logic [POS_W-1:0]  o_position
);

    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam int BRAKE_W = $clog2(BRAKE_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [BRAKE_W-1:0] BRAKE_LAST = BRAKE_W'(BRAKE_CYCLES - 1);

`ifdef MOTOR_SEQ_REVERSE_FAULT_EN
    localparam logic REV_FAULT_EN = 1'b1;
`else
    localparam logic REV_FAULT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BRAKE, S_DONE} state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ABORT   = 2'b01;
    localparam logic [1:0] ST_STALL   = 2'b10;
    localparam logic [1:0] ST_REVERSE = 2'b11;

    state_t             state_q;
    logic [STEP_W-1:0]  remaining_q;
    logic [STALL_W-1:0] stall_q;
    logic [BRAKE_W-1:0] brake_q;
    logic [POS_W-1:0]   pos_q;
    logic [1:0]         status_q;
    logic               ready_q, en_q, dir_q, busy_q, done_q;

    logic fwd_step, rev_step, last_step, stall_hit, rev_fault;

    always_comb begin
        fwd_step  = i_step && (i_polarity == dir_q);
        rev_step  = i_step && !fwd_step;
        last_step = fwd_step && (remaining_q == STEP_W'(1));
        stall_hit = !i_step && (stall_q == STALL_LAST);
        rev_fault = REV_FAULT_EN && rev_step;
    end

    // NOTE: all state here is sequential, so every assignment uses <= to read pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            stall_q     <= '0;
            brake_q     <= '0;
            pos_q       <= '0;
            status_q    <= ST_OK;
            ready_q     <= 1'b1;
            en_q        <= 1'b0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Position tracks every decoded step, including coasting outside RUN.
            if (i_step) begin
                pos_q <= i_polarity ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        remaining_q <= i_cmd_steps;
                        dir_q       <= i_cmd_dir;
                        status_q    <= ST_OK;
                        stall_q     <= '0;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        if (i_cmd_steps != '0) begin
                            state_q <= S_RUN;
                            en_q    <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (fwd_step) begin
                        remaining_q <= remaining_q - STEP_W'(1);
                    end
                    if (i_step) begin
                        stall_q <= '0;
                    end else if (stall_q != STALL_MAX) begin
                        stall_q <= stall_q + STALL_W'(1);
                    end
                    if (last_step || rev_fault || i_abort || stall_hit) begin
                        state_q <= S_BRAKE;
                        en_q    <= 1'b0;
                        brake_q <= '0;
                        // Completion wins over every fault raised in the same cycle.
                        if (last_step)      status_q <= ST_OK;
                        else if (rev_fault) status_q <= ST_REVERSE;
                        else if (i_abort)   status_q <= ST_ABORT;
                        else                status_q <= ST_STALL;
                    end
                end

                S_BRAKE: begin
                    if (brake_q == BRAKE_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        brake_q <= brake_q + BRAKE_W'(1);
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = ready_q;
    assign o_motor_en  = en_q;
    assign o_motor_dir = dir_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_status    = status_q;
    assign o_position  = pos_q;

endmodule
